// File: rtl/sbuf_pkg.sv
// Shared constants and FSM state type for the sbuf read streamer.
package sbuf_pkg;

   localparam int unsigned ADR_W  = 8;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned LEN_W  = ADR_W + 1;

   typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

endpackage

// File: rtl/sbuf_rd_streamer_if.sv
// Valid/ready word stream from the read streamer to a systolic-array edge.
interface sbuf_rd_streamer_if #(
   parameter int unsigned DATA_W = sbuf_pkg::DATA_W
) ();

   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_last;
   logic              out_ready;

   modport master (output out_valid, output out_data, output out_last, input out_ready);
   modport slave  (input out_valid, input out_data, input out_last, output out_ready);

endinterface

// File: rtl/sbuf_skid2.sv
// Two-entry synchronous FIFO with a registered head; absorbs the RAM read latency.
module sbuf_skid2 #(
   parameter int unsigned W = 17
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [1:0]   count,
   output logic         empty,
   output logic [W-1:0] head
);

   logic [W-1:0] mem_q [2];
   logic         wr_ptr_q;
   logic         rd_ptr_q;
   logic [1:0]   count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= push_data;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign count = count_q;
   assign empty = (count_q == 2'd0);
   assign head  = mem_q[rd_ptr_q];

   // The issue rule in the parent guarantees neither can happen.
   a_no_overflow : assert property (@(posedge clk) disable iff (rst)
      !(push && !pop && count_q == 2'd2));
   a_no_underflow : assert property (@(posedge clk) disable iff (rst)
      !(pop && count_q == 2'd0));

endmodule

// File: rtl/sbuf_rd_streamer.sv
// Drains a contiguous (wrapping) buffer region into a valid/ready stream, 1 word/clk sustained.
module sbuf_rd_streamer
   import sbuf_pkg::*;
#(
   parameter int unsigned ADR_W  = sbuf_pkg::ADR_W,
   parameter int unsigned DATA_W = sbuf_pkg::DATA_W,
   parameter int unsigned LEN_W  = sbuf_pkg::LEN_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADR_W-1:0]  base_adr,
   input  logic [LEN_W-1:0]  length,
   output logic              busy,
   output logic              done,
   output logic [ADR_W-1:0]  ram_radr,
   input  logic [DATA_W-1:0] ram_rdata,
   sbuf_rd_streamer_if.master stream
);

   state_e             state_q, state_d;
   logic [ADR_W-1:0]   cur_adr_q, cur_adr_d;
   logic [ADR_W-1:0]   radr_q, radr_d;
   logic [LEN_W-1:0]   remaining_q, remaining_d;
   logic               rd_pend_q, rd_pend_d;
   logic               last_pend_q, last_pend_d;
   logic               done_q, done_d;

   logic               issue;
   logic               pop;
   logic               fifo_empty;
   logic [1:0]         fifo_cnt;
   logic [2:0]         occ;
   logic [DATA_W:0]    head;

   assign pop   = !fifo_empty && stream.out_ready;
   // Slots committed after this cycle: stored words plus the in-flight read, less a pop.
   assign occ   = {1'b0, fifo_cnt} + {2'b00, rd_pend_q} - {2'b00, pop};
   assign issue = (state_q == StRun) && (occ < 3'd2);

   always_comb begin
      state_d     = state_q;
      cur_adr_d   = cur_adr_q;
      radr_d      = radr_q;
      remaining_d = remaining_q;
      rd_pend_d   = issue;
      last_pend_d = issue && (remaining_q == LEN_W'(1));
      done_d      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               cur_adr_d   = base_adr;
               remaining_d = length;
               if (length != '0) state_d = StRun;
               else              done_d  = 1'b1;
            end
         end
         StRun: begin
            if (issue) begin
               radr_d      = cur_adr_q;
               cur_adr_d   = cur_adr_q + ADR_W'(1);
               remaining_d = remaining_q - LEN_W'(1);
               if (remaining_q == LEN_W'(1)) state_d = StDrain;
            end
         end
         StDrain: begin
            if (pop && head[DATA_W]) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         cur_adr_q   <= '0;
         radr_q      <= '0;
         remaining_q <= '0;
         rd_pend_q   <= 1'b0;
         last_pend_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cur_adr_q   <= cur_adr_d;
         radr_q      <= radr_d;
         remaining_q <= remaining_d;
         rd_pend_q   <= rd_pend_d;
         last_pend_q <= last_pend_d;
         done_q      <= done_d;
      end
   end

   sbuf_skid2 #(
      .W (DATA_W + 1)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .push      (rd_pend_q),
      .push_data ({last_pend_q, ram_rdata}),
      .pop       (pop),
      .count     (fifo_cnt),
      .empty     (fifo_empty),
      .head      (head)
   );

   assign ram_radr         = issue ? cur_adr_q : radr_q;
   assign busy             = (state_q != StIdle);
   assign done             = done_q;
   assign stream.out_valid = !fifo_empty;
   assign stream.out_data  = head[DATA_W-1:0];
   assign stream.out_last  = head[DATA_W];

endmodule

// File: tb/tb_sbuf_rd_streamer.sv
// Directed bench for sbuf_rd_streamer against a registered-read buffer model.
module tb_sbuf_rd_streamer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  base_adr = '0;
   logic [8:0]  length = '0;
   logic        busy, done;
   logic [7:0]  ram_radr;
   logic [15:0] ram_rdata = '0;
   logic [15:0] mem [256];

   sbuf_rd_streamer_if #(.DATA_W(16)) s_if ();

   sbuf_rd_streamer dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_adr  (base_adr),
      .length    (length),
      .busy      (busy),
      .done      (done),
      .ram_radr  (ram_radr),
      .ram_rdata (ram_rdata),
      .stream    (s_if)
   );

   always #5 clk = ~clk;

   initial for (int i = 0; i < 256; i++) mem[i] = 16'hA000 + 16'(i);
   always_ff @(posedge clk) ram_rdata <= mem[ram_radr];

   int checks = 0;
   int errors = 0;
   logic [15:0] got_q[$];
   int n_last, last_pos, first_cyc, done_cyc, stab_err, max_cnt;
   logic busy_c0, busy_c1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulses start in cycle 0 and records the stream until done (bounded).
   task automatic run_drain(input logic [7:0] b, input logic [8:0] n, input bit rnd,
                            input int restart_at);
      bit          stall_prev;
      logic [15:0] d_prev;
      logic        l_prev;
      stall_prev = 1'b0; d_prev = '0; l_prev = 1'b0;
      got_q.delete();
      n_last = 0; last_pos = -1; first_cyc = -1; done_cyc = -1; stab_err = 0; max_cnt = 0;
      start = 1'b1; base_adr = b; length = n; s_if.out_ready = 1'b1;
      for (int c = 0; c < 700; c++) begin
         @(negedge clk);
         if (c == 0) busy_c0 = busy;
         if (c == 1) busy_c1 = busy;
         if (stall_prev && !(s_if.out_valid && s_if.out_data == d_prev && s_if.out_last == l_prev))
            stab_err++;
         if (int'(dut.fifo_cnt) > max_cnt) max_cnt = int'(dut.fifo_cnt);
         if (s_if.out_valid && first_cyc < 0) first_cyc = c;
         if (s_if.out_valid && s_if.out_ready) begin
            got_q.push_back(s_if.out_data);
            if (s_if.out_last) begin n_last++; last_pos = got_q.size() - 1; end
         end
         stall_prev = s_if.out_valid && !s_if.out_ready;
         d_prev = s_if.out_data;
         l_prev = s_if.out_last;
         if (done) begin done_cyc = c; break; end
         tick();
         start = (c + 1 == restart_at);
         if (start) begin base_adr = 8'h00; length = 9'd2; end
         s_if.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      tick();
      start = 1'b0;
      s_if.out_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1; s_if.out_ready = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
      checks++; if (s_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", s_if.out_valid); end
      checks++; if (s_if.out_last !== 1'b0) begin errors++; $display("FAIL reset_last got %b want 0", s_if.out_last); end
      checks++; if (ram_radr !== 8'h00) begin errors++; $display("FAIL reset_radr got %h want 00", ram_radr); end
      checks++; if (s_if.out_data !== 16'h0000) begin errors++; $display("FAIL reset_data got %h want 0000", s_if.out_data); end
      tick();
   endtask

   task automatic test_basic();
      run_drain(8'h10, 9'd4, 1'b0, -1);
      checks++; if (busy_c0 !== 1'b0) begin errors++; $display("FAIL basic_busy_c0 got %b want 0", busy_c0); end
      checks++; if (busy_c1 !== 1'b1) begin errors++; $display("FAIL basic_busy_c1 got %b want 1", busy_c1); end
      checks++; if (first_cyc != 3) begin errors++; $display("FAIL basic_first_valid got %0d want 3", first_cyc); end
      checks++; if (done_cyc != 7) begin errors++; $display("FAIL basic_done_cycle got %0d want 7", done_cyc); end
      checks++; if (got_q.size() != 4) begin errors++; $display("FAIL basic_count got %0d want 4", got_q.size()); end
      for (int i = 0; i < got_q.size() && i < 4; i++) begin
         checks++;
         if (got_q[i] !== 16'hA010 + 16'(i)) begin
            errors++; $display("FAIL basic_word%0d got %h want %h", i, got_q[i], 16'hA010 + 16'(i));
         end
      end
      checks++; if (n_last != 1 || last_pos != 3) begin errors++; $display("FAIL basic_last got n=%0d pos=%0d want n=1 pos=3", n_last, last_pos); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %b want 0", busy); end
   endtask

   task automatic test_wrap();
      logic [15:0] exp_w [4];
      exp_w[0] = 16'hA0FE; exp_w[1] = 16'hA0FF; exp_w[2] = 16'hA000; exp_w[3] = 16'hA001;
      run_drain(8'hFE, 9'd4, 1'b0, -1);
      checks++; if (got_q.size() != 4) begin errors++; $display("FAIL wrap_count got %0d want 4", got_q.size()); end
      for (int i = 0; i < got_q.size() && i < 4; i++) begin
         checks++;
         if (got_q[i] !== exp_w[i]) begin
            errors++; $display("FAIL wrap_word%0d got %h want %h", i, got_q[i], exp_w[i]);
         end
      end
   endtask

   task automatic test_full();
      int bad;
      bad = 0;
      run_drain(8'h00, 9'd256, 1'b0, -1);
      checks++; if (got_q.size() != 256) begin errors++; $display("FAIL full_count got %0d want 256", got_q.size()); end
      for (int i = 0; i < got_q.size() && i < 256; i++) if (got_q[i] !== 16'hA000 + 16'(i)) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL full_words got %0d bad want 0 bad", bad); end
      checks++; if (done_cyc != 259) begin errors++; $display("FAIL full_done_cycle got %0d want 259", done_cyc); end
      checks++; if (last_pos != 255) begin errors++; $display("FAIL full_last got %0d want 255", last_pos); end
   endtask

   task automatic test_backpressure();
      run_drain(8'h30, 9'd8, 1'b1, -1);
      checks++; if (done_cyc < 0) begin errors++; $display("FAIL bp_timeout got no done want done"); end
      checks++; if (got_q.size() != 8) begin errors++; $display("FAIL bp_count got %0d want 8", got_q.size()); end
      for (int i = 0; i < got_q.size() && i < 8; i++) begin
         checks++;
         if (got_q[i] !== 16'hA030 + 16'(i)) begin
            errors++; $display("FAIL bp_word%0d got %h want %h", i, got_q[i], 16'hA030 + 16'(i));
         end
      end
      checks++; if (stab_err != 0) begin errors++; $display("FAIL bp_stable got %0d changes want 0", stab_err); end
      checks++; if (max_cnt > 2) begin errors++; $display("FAIL bp_fifo_count got %0d want <=2", max_cnt); end
      checks++; if (n_last != 1 || last_pos != 7) begin errors++; $display("FAIL bp_last got n=%0d pos=%0d want n=1 pos=7", n_last, last_pos); end
   endtask

   task automatic test_zero_len();
      bit bad;
      bad = 1'b0;
      start = 1'b1; base_adr = 8'h33; length = 9'd0; s_if.out_ready = 1'b1;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy_c0 got %b want 0", busy); end
      tick();
      start = 1'b0;
      @(negedge clk);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done got %b want 1", done); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy got %b want 0", busy); end
      for (int c = 0; c < 4; c++) begin
         tick();
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0 || s_if.out_valid !== 1'b0) bad = 1'b1;
      end
      checks++; if (bad) begin errors++; $display("FAIL zero_quiet got activity want none"); end
      tick();
   endtask

   task automatic test_restart_ignored();
      run_drain(8'h40, 9'd6, 1'b0, 3);
      checks++; if (got_q.size() != 6) begin errors++; $display("FAIL restart_count got %0d want 6", got_q.size()); end
      for (int i = 0; i < got_q.size() && i < 6; i++) begin
         checks++;
         if (got_q[i] !== 16'hA040 + 16'(i)) begin
            errors++; $display("FAIL restart_word%0d got %h want %h", i, got_q[i], 16'hA040 + 16'(i));
         end
      end
      checks++; if (done_cyc != 9) begin errors++; $display("FAIL restart_done_cycle got %0d want 9", done_cyc); end
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL restart_idle got %b want 0", busy); end
   endtask

   task automatic test_reset_mid();
      bit bad;
      bad = 1'b0;
      start = 1'b1; base_adr = 8'h50; length = 9'd8; s_if.out_ready = 1'b0;
      tick();
      start = 1'b0;
      repeat (4) tick();
      @(negedge clk);
      checks++; if (s_if.out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre_valid got %b want 1", s_if.out_valid); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
      checks++; if (s_if.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", s_if.out_valid); end
      checks++; if (s_if.out_last !== 1'b0) begin errors++; $display("FAIL rstmid_last got %b want 0", s_if.out_last); end
      checks++; if (ram_radr !== 8'h00) begin errors++; $display("FAIL rstmid_radr got %h want 00", ram_radr); end
      checks++; if (s_if.out_data !== 16'h0000) begin errors++; $display("FAIL rstmid_data got %h want 0000", s_if.out_data); end
      s_if.out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         if (done !== 1'b0 || s_if.out_valid !== 1'b0) bad = 1'b1;
         tick();
         @(negedge clk);
      end
      checks++; if (bad) begin errors++; $display("FAIL rstmid_quiet got activity want none"); end
      tick();
      run_drain(8'h60, 9'd3, 1'b0, -1);
      checks++; if (done_cyc != 6) begin errors++; $display("FAIL rstmid_new_done got %0d want 6", done_cyc); end
      checks++; if (got_q.size() != 3) begin errors++; $display("FAIL rstmid_new_count got %0d want 3", got_q.size()); end
      for (int i = 0; i < got_q.size() && i < 3; i++) begin
         checks++;
         if (got_q[i] !== 16'hA060 + 16'(i)) begin
            errors++; $display("FAIL rstmid_word%0d got %h want %h", i, got_q[i], 16'hA060 + 16'(i));
         end
      end
   endtask

   initial begin
      s_if.out_ready = 1'b0;
      test_reset();
      test_basic();
      test_wrap();
      test_full();
      test_backpressure();
      test_zero_len();
      test_restart_ignored();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
